multi_lane_mac_unit: RTL and testbench

MULTI_LANE_MAC_UNIT -- requirements
Module: multi_lane_mac_unit

---
 rtl/mac_pkg.sv | 28 ++
 rtl/fixed_point_mult_pipe.sv | 45 ++++
 rtl/multi_lane_mac_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_multi_lane_mac_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multi-lane MAC unit.
//   - default widths and latency (pixel sfix10_En0, weight sfix19_En18,
//     result sfix26_En18)
//   - FRAC_BITS: fractional bits of weights, products, accumulator and result
//   - mac_state_e: controller states
//   - DEF_SAT_MAX / DEF_SAT_MIN: saturation limits of the default result width
package mac_pkg;

  localparam int DEF_NUM_INPUTS   = 16;
  localparam int DEF_NUM_LANES    = 4;
  localparam int DEF_PIXEL_WIDTH  = 10;
  localparam int DEF_WEIGHT_WIDTH = 19;
  localparam int DEF_OUTPUT_WIDTH = 26;
  localparam int DEF_MULT_LATENCY = 2;
  localparam int FRAC_BITS        = 18;

  localparam logic [DEF_OUTPUT_WIDTH-1:0] DEF_SAT_MAX = 26'h1FF_FFFF;
  localparam logic [DEF_OUTPUT_WIDTH-1:0] DEF_SAT_MIN = 26'h200_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } mac_state_e;

endpackage

// File: rtl/fixed_point_mult_pipe.sv
// fixed_point_mult_pipe: one multiplier lane.
//   clk     - clock, rising edge
//   rst     - synchronous active-low reset, flushes every pipeline stage
//   pixel   - signed pixel operand (En0)
//   weight  - signed weight operand (En18)
//   product - full-precision signed product (En18), MULT_LATENCY cycles later
module fixed_point_mult_pipe #(
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int MULT_LATENCY = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [PIXEL_WIDTH-1:0]               pixel,
  input  logic signed [WEIGHT_WIDTH-1:0]              weight,
  output logic signed [PIXEL_WIDTH+WEIGHT_WIDTH-1:0]  product
);

  localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH;

  logic signed [PROD_W-1:0] stage_q [MULT_LATENCY];
  logic signed [PROD_W-1:0] stage_d [MULT_LATENCY];

  // Multiply into the first stage, then shift down the delay line.
  always_comb begin
    stage_d[0] = PROD_W'(pixel) * PROD_W'(weight);
    for (int i = 1; i < MULT_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Pipeline registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign product = stage_q[MULT_LATENCY-1];

endmodule

// File: rtl/multi_lane_mac_unit.sv
// multi_lane_mac_unit: signed fixed-point dot product of NUM_INPUTS
// pixel/weight pairs on NUM_LANES pipelined multipliers, plus bias,
// saturation to OUTPUT_WIDTH and optional ReLU.
//   clk, rst           - clock; synchronous active-low reset
//   start              - request an operation (ignored while busy)
//   IN_PIXELS/WEIGHTS  - packed operands, element i at [i*W +: W]
//   bias, relu_en      - captured together with the operands
//   busy               - operation in progress
//   out_valid          - one-cycle result strobe
//   OUT, saturated     - result and clip flag, held until the next strobe
module multi_lane_mac_unit
  import mac_pkg::*;
#(
  parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int NUM_LANES    = DEF_NUM_LANES,
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    IN_PIXELS,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   IN_WEIGHTS,
  input  logic [OUTPUT_WIDTH-1:0]              bias,
  input  logic                                 relu_en,
  output logic                                 busy,
  output logic                                 out_valid,
  output logic [OUTPUT_WIDTH-1:0]              OUT,
  output logic                                 saturated
);

  localparam int BEATS  = NUM_INPUTS / NUM_LANES;
  localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_INPUTS);
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int DRN_W  = $clog2(MULT_LATENCY) + 1;
  localparam int PIX_BUS = NUM_INPUTS * PIXEL_WIDTH;
  localparam int WGT_BUS = NUM_INPUTS * WEIGHT_WIDTH;

  localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  mac_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [DRN_W-1:0]           drain_q, drain_d;
  logic [PIX_BUS-1:0]         pix_q, pix_d;
  logic [WGT_BUS-1:0]         wgt_q, wgt_d;
  logic signed [OUTPUT_WIDTH-1:0] bias_q, bias_d;
  logic                       relu_q, relu_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [MULT_LATENCY-1:0]    vld_q, vld_d;
  logic [OUTPUT_WIDTH-1:0]    out_q, out_d;
  logic                       sat_q, sat_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;

  logic signed [PROD_W-1:0]       lane_prod [NUM_LANES];
  logic signed [ACC_W-1:0]        lane_sum_s;
  logic signed [SUM_W-1:0]        sum_s;
  logic signed [OUTPUT_WIDTH-1:0] clip_s;
  logic                           clip_sat_s;
  logic [OUTPUT_WIDTH-1:0]        result_s;

  // The operand registers shift one beat per RUN cycle, so every lane
  // always reads a fixed slice of the low end.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fixed_point_mult_pipe #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .MULT_LATENCY(MULT_LATENCY)
    ) u_mult (
      .clk    (clk),
      .rst    (rst),
      .pixel  (pix_q[l*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .weight (wgt_q[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .product(lane_prod[l])
    );
  end

  // Sign-extend and add the lane products of the beat leaving the pipes.
  always_comb begin
    lane_sum_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_sum_s = lane_sum_s + ACC_W'(lane_prod[l]);
    end
  end

  // Bias add, clip to the output range, then ReLU. A negative result that
  // clipped still reports saturated even though ReLU forces it to zero.
  always_comb begin
    sum_s = SUM_W'(acc_q) + SUM_W'(bias_q);
    if (sum_s > SUM_W'(OUT_MAX)) begin
      clip_s     = OUT_MAX;
      clip_sat_s = 1'b1;
    end else if (sum_s < SUM_W'(OUT_MIN)) begin
      clip_s     = OUT_MIN;
      clip_sat_s = 1'b1;
    end else begin
      clip_s     = sum_s[OUTPUT_WIDTH-1:0];
      clip_sat_s = 1'b0;
    end
    if (relu_q && clip_s[OUTPUT_WIDTH-1]) begin
      result_s = '0;
    end else begin
      result_s = clip_s;
    end
  end

  // Controller next-state logic. The valid shift register tracks which
  // pipeline slots carry real beats, so DRAIN can be a plain fixed count.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    pix_d       = pix_q;
    wgt_d       = wgt_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    vld_d[0]    = (state_q == RUN);
    for (int i = 1; i < MULT_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (vld_q[MULT_LATENCY-1]) begin
      acc_d = acc_q + lane_sum_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          pix_d   = IN_PIXELS;
          wgt_d   = IN_WEIGHTS;
          bias_d  = bias;
          relu_d  = relu_en;
          acc_d   = '0;
          beat_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      // LOAD is part of the state encoding, but capture happens on the
      // IDLE exit so it is never entered in normal operation.
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        pix_d = pix_q >> (NUM_LANES * PIXEL_WIDTH);
        wgt_d = wgt_q >> (NUM_LANES * WEIGHT_WIDTH);
        if (beat_q == CNT_W'(BEATS - 1)) begin
          beat_d  = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(MULT_LATENCY - 1)) begin
          state_d = FINISH;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      FINISH: begin
        out_d       = result_s;
        sat_d       = clip_sat_s;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      drain_q     <= '0;
      pix_q       <= '0;
      wgt_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      vld_q       <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      vld_q       <= vld_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_multi_lane_mac_unit.sv
// Self-checking bench for multi_lane_mac_unit: four instances sharing the
// stimulus (lanes/latency 4/2, 1/3, 2/2, 16/1), directed steps followed by a
// randomized sweep, all against a plain-arithmetic saturating dot product.
module tb_multi_lane_mac_unit;

  localparam int NI = 16;
  localparam int PW = 10;
  localparam int WW = 19;
  localparam int OW = 26;

  typedef struct {
    int          c;
    logic [25:0] o;
    logic        s;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [NI*PW-1:0]    pixels_v;
  logic [NI*WW-1:0]    weights_v;
  logic [OW-1:0]       bias_v;
  logic                relu_v;

  logic                busy_w  [4];
  logic                ov_w    [4];
  logic [OW-1:0]       out_w   [4];
  logic                sat_w   [4];

  int                  lat_exp [4];
  int                  pix_a   [NI];
  int                  wgt_a   [NI];
  int                  bias_i;
  bit                  relu_i;
  ev_t                 evq     [4][$];
  int                  cyc = 0;
  int                  checks = 0;
  int                  failures = 0;
  logic [25:0]         last_out0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ov_w[k] === 1'b1) begin
        ev_t e;
        e.c = cyc;
        e.o = out_w[k];
        e.s = sat_w[k];
        evq[k].push_back(e);
      end
    end
  end

  multi_lane_mac_unit #(.NUM_INPUTS(16), .NUM_LANES(4), .PIXEL_WIDTH(10),
    .WEIGHT_WIDTH(19), .OUTPUT_WIDTH(26), .MULT_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .IN_PIXELS(pixels_v), .IN_WEIGHTS(weights_v),
    .bias(bias_v), .relu_en(relu_v), .busy(busy_w[0]), .out_valid(ov_w[0]),
    .OUT(out_w[0]), .saturated(sat_w[0]));

  multi_lane_mac_unit #(.NUM_INPUTS(16), .NUM_LANES(1), .PIXEL_WIDTH(10),
    .WEIGHT_WIDTH(19), .OUTPUT_WIDTH(26), .MULT_LATENCY(3)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .IN_PIXELS(pixels_v), .IN_WEIGHTS(weights_v),
    .bias(bias_v), .relu_en(relu_v), .busy(busy_w[1]), .out_valid(ov_w[1]),
    .OUT(out_w[1]), .saturated(sat_w[1]));

  multi_lane_mac_unit #(.NUM_INPUTS(16), .NUM_LANES(2), .PIXEL_WIDTH(10),
    .WEIGHT_WIDTH(19), .OUTPUT_WIDTH(26), .MULT_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .IN_PIXELS(pixels_v), .IN_WEIGHTS(weights_v),
    .bias(bias_v), .relu_en(relu_v), .busy(busy_w[2]), .out_valid(ov_w[2]),
    .OUT(out_w[2]), .saturated(sat_w[2]));

  multi_lane_mac_unit #(.NUM_INPUTS(16), .NUM_LANES(16), .PIXEL_WIDTH(10),
    .WEIGHT_WIDTH(19), .OUTPUT_WIDTH(26), .MULT_LATENCY(1)) u_l16 (
    .clk(clk), .rst(rst), .start(start), .IN_PIXELS(pixels_v), .IN_WEIGHTS(weights_v),
    .bias(bias_v), .relu_en(relu_v), .busy(busy_w[3]), .out_valid(ov_w[3]),
    .OUT(out_w[3]), .saturated(sat_w[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product plus bias, clip to 26-bit signed, ReLU.
  function automatic void model(output logic [25:0] o, output logic s);
    longint acc;
    longint res;
    acc = longint'(bias_i);
    for (int i = 0; i < NI; i++) acc += longint'(pix_a[i]) * longint'(wgt_a[i]);
    if (acc > 64'sd33554431) begin
      res = 64'sd33554431;
      s   = 1'b1;
    end else if (acc < -64'sd33554432) begin
      res = -64'sd33554432;
      s   = 1'b1;
    end else begin
      res = acc;
      s   = 1'b0;
    end
    if (relu_i && res < 0) res = 0;
    o = res[25:0];
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < NI; i++) begin
      pixels_v[i*PW +: PW]  = pix_a[i][PW-1:0];
      weights_v[i*WW +: WW] = wgt_a[i][WW-1:0];
    end
    bias_v = bias_i[OW-1:0];
    relu_v = relu_i;
  endtask

  task automatic set_all(input int p, input int w, input int b, input bit r);
    for (int i = 0; i < NI; i++) begin
      pix_a[i] = p;
      wgt_a[i] = w;
    end
    bias_i = b;
    relu_i = r;
  endtask

  task automatic set_basic();
    set_all(0, 65536, 0, 1'b0);
    for (int i = 0; i < 4; i++) pix_a[i] = i + 1;
  endtask

  task automatic clear_events();
    for (int k = 0; k < 4; k++) evq[k].delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One start pulse; checks pulse count, latency, OUT, saturated and hold
  // on the first kmax instances.
  task automatic run_and_check(input string tag, input int kmax);
    logic [25:0] eo;
    logic        es;
    int          c0;
    bit          got;
    pack_inputs();
    model(eo, es);
    clear_events();
    last_out0 = 26'bx;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    while (!got && (cyc < c0 + 40)) begin
      @(negedge clk);
      got = 1'b1;
      for (int k = 0; k < kmax; k++) if (evq[k].size() == 0) got = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < kmax; k++) begin
      string t;
      t = $sformatf("%s_d%0d", tag, k);
      check({t, "_pulses"}, 64'(evq[k].size()), 64'd1);
      if (evq[k].size() > 0) begin
        check({t, "_latency"}, 64'(evq[k][0].c - c0), 64'(lat_exp[k]));
        check({t, "_out"}, 64'(evq[k][0].o), 64'(eo));
        check({t, "_sat"}, 64'(evq[k][0].s), 64'(es));
        check({t, "_hold"}, 64'(out_w[k]), 64'(eo));
        if (k == 0) last_out0 = evq[0][0].o;
      end
    end
  endtask

  initial begin
    logic [25:0] ea, eb;
    logic        sa, sb;
    int          c0;

    lat_exp[0] = 16 / 4 + 2 + 2;
    lat_exp[1] = 16 / 1 + 3 + 2;
    lat_exp[2] = 16 / 2 + 2 + 2;
    lat_exp[3] = 16 / 16 + 1 + 2;
    rst   = 1'b0;
    start = 1'b0;
    set_all(0, 0, 0, 1'b0);
    pack_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_out_valid", 64'(ov_w[0]), 64'd0);
    check("rst_out", 64'(out_w[0]), 64'd0);
    check("rst_sat", 64'(sat_w[0]), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic dot product
    set_basic();
    run_and_check("basic", 1);
    check("basic_literal", 64'(last_out0), 64'd655360);

    // Positive and negative saturation
    set_all(100, 131072, 0, 1'b0);
    run_and_check("pos_sat", 1);
    check("pos_sat_literal", 64'(last_out0), 64'h1FF_FFFF);
    set_all(-100, 131072, 0, 1'b0);
    run_and_check("neg_sat", 1);
    check("neg_sat_literal", 64'(last_out0), 64'h200_0000);

    // Bias and ReLU
    set_all(0, 131072, 262144, 1'b0);
    pix_a[0] = -10;
    run_and_check("bias", 1);
    check("bias_literal", 64'(last_out0), 64'h3F0_0000);
    relu_i = 1'b1;
    run_and_check("relu", 1);
    check("relu_literal", 64'(last_out0), 64'd0);
    set_all(-100, 131072, 0, 1'b1);
    run_and_check("relu_negsat", 1);

    // Back-to-back with start held high; data changes while busy
    set_basic();
    pack_inputs();
    model(ea, sa);
    clear_events();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    check("b2b_busy", 64'(busy_w[0]), 64'd1);
    for (int i = 0; i < NI; i++) begin
      pix_a[i] = int'($urandom_range(0, 1023)) - 512;
      wgt_a[i] = int'($urandom_range(0, 8191)) - 4096;
    end
    bias_i = 1234;
    relu_i = 1'b0;
    pack_inputs();
    model(eb, sb);
    while (cyc < c0 + 9) @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 30) @(negedge clk);
    check("b2b_pulses", 64'(evq[0].size()), 64'd2);
    if (evq[0].size() == 2) begin
      check("b2b_first_cycle", 64'(evq[0][0].c - c0), 64'd8);
      check("b2b_second_cycle", 64'(evq[0][1].c - c0), 64'd16);
      check("b2b_first_out", 64'(evq[0][0].o), 64'(ea));
      check("b2b_second_out", 64'(evq[0][1].o), 64'(eb));
      check("b2b_second_sat", 64'(evq[0][1].s), 64'(sb));
    end

    // Reset during beat 2 aborts the operation
    do_reset();
    repeat (25) @(negedge clk);
    set_basic();
    pack_inputs();
    clear_events();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", 64'(busy_w[0]), 64'd0);
    repeat (15) @(negedge clk);
    check("abort_no_pulse", 64'(evq[0].size()), 64'd0);
    run_and_check("after_abort", 1);
    check("after_abort_literal", 64'(last_out0), 64'd655360);

    // Lane-count sweep with random operands
    do_reset();
    repeat (2) @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NI; i++) begin
        pix_a[i] = int'($urandom_range(0, 1023)) - 512;
        if (t % 2 == 0) wgt_a[i] = int'($urandom_range(0, 524287)) - 262144;
        else            wgt_a[i] = int'($urandom_range(0, 8191)) - 4096;
      end
      bias_i = int'($urandom_range(0, 67108863)) - 33554432;
      relu_i = bit'($urandom_range(0, 1));
      run_and_check($sformatf("sweep%0d", t), 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
